// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI master/slave loopback.
package spi_pkg;

  localparam int DATA_W  = 12;
  localparam int CLK_DIV = 10;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W   = $clog2(DATA_W + 1);

  typedef enum logic {
    IDLE,
    SEND
  } masterState_e;

endpackage

// File: rtl/spi_master.sv
// SPI master: free-running sclk divider plus a serialiser that shifts a
// captured word out LSB first, changing mosi only on sclk rising ticks.
module spi_master
  import spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_newd,
  input  logic [DATA_W-1:0] i_din,
  output logic              sclk,
  output logic              o_cs,
  output logic              o_mosi,
  output logic              o_sclkTick
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W);

  logic [DIV_W-1:0]  r_divCnt;
  logic              w_riseTick;

  masterState_e      r_state, w_stateNext;
  logic [DATA_W-1:0] r_data, w_dataNext;
  logic [CNT_W-1:0]  r_bitCnt, w_bitCntNext;
  logic              r_pending, w_pendingNext;
  logic              r_cs, w_csNext;
  logic              r_mosi, w_mosiNext;

  // The tick marks the cycle on which sclk toggles; its direction follows
  // from the current sclk level, so the slave can derive the falling tick.
  assign o_sclkTick = (r_divCnt == DIV_LAST);
  assign w_riseTick = o_sclkTick & ~sclk;
  assign o_cs       = r_cs;
  assign o_mosi     = r_mosi;

  // Divider counts 0..CLK_DIV-1 and toggles sclk on every wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_divCnt <= '0;
      sclk     <= 1'b0;
    end else if (o_sclkTick) begin
      r_divCnt <= '0;
      sclk     <= ~sclk;
    end else begin
      r_divCnt <= r_divCnt + 1'b1;
    end
  end

  // State register for the transmit FSM and its datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_data    <= '0;
      r_bitCnt  <= '0;
      r_pending <= 1'b0;
      r_cs      <= 1'b1;
      r_mosi    <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_data    <= w_dataNext;
      r_bitCnt  <= w_bitCntNext;
      r_pending <= w_pendingNext;
      r_cs      <= w_csNext;
      r_mosi    <= w_mosiNext;
    end
  end

  // Next-state logic: a request latched in IDLE starts a frame on the next
  // rising tick; requests arriving during SEND are dropped, not queued.
  always_comb begin
    w_stateNext   = r_state;
    w_dataNext    = r_data;
    w_bitCntNext  = r_bitCnt;
    w_pendingNext = r_pending;
    w_csNext      = r_cs;
    w_mosiNext    = r_mosi;
    case (r_state)
      IDLE: begin
        w_csNext   = 1'b1;
        w_mosiNext = 1'b0;
        if (w_riseTick && r_pending) begin
          w_dataNext    = i_din;
          w_csNext      = 1'b0;
          w_mosiNext    = i_din[0];
          w_bitCntNext  = CNT_W'(1);
          w_pendingNext = 1'b0;
          w_stateNext   = SEND;
        end else if (i_newd) begin
          w_pendingNext = 1'b1;
        end
      end
      SEND: begin
        if (w_riseTick) begin
          if (r_bitCnt < BIT_LAST) begin
            w_mosiNext   = r_data[r_bitCnt];
            w_bitCntNext = r_bitCnt + 1'b1;
          end else begin
            w_csNext    = 1'b1;
            w_mosiNext  = 1'b0;
            w_stateNext = IDLE;
          end
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

endmodule

// File: rtl/spi_slave.sv
// SPI slave: samples mosi on sclk falling ticks while cs is low and
// assembles an LSB-first word, presenting it with a one-cycle done pulse.
module spi_slave
  import spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_sclk,
  input  logic              i_sclkTick,
  input  logic              i_cs,
  input  logic              i_mosi,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_done
);

  localparam logic [CNT_W-1:0] RCV_LAST = CNT_W'(DATA_W - 1);

  logic              w_fallTick;
  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_rcnt;

  // A tick while sclk is still high is the cycle on which sclk falls.
  assign w_fallTick = i_sclkTick & i_sclk;

  // Shift in on falling ticks; the last bit publishes the word and pulses done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_rcnt  <= '0;
      o_dout  <= '0;
      o_done  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_cs) begin
        r_rcnt <= '0;
      end else if (w_fallTick) begin
        r_shift <= {i_mosi, r_shift[DATA_W-1:1]};
        if (r_rcnt == RCV_LAST) begin
          o_dout <= {i_mosi, r_shift[DATA_W-1:1]};
          o_done <= 1'b1;
          r_rcnt <= '0;
        end else begin
          r_rcnt <= r_rcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_loopback_top.sv
// Loopback top: SPI master wired straight into SPI slave, no extra logic.
module spi_loopback_top
  import spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              newd,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              done
);

  logic w_sclk;
  logic w_sclkTick;
  logic w_cs;
  logic w_mosi;

  spi_master m1 (
    .clk        (clk),
    .rst        (rst),
    .i_newd     (newd),
    .i_din      (din),
    .sclk       (w_sclk),
    .o_cs       (w_cs),
    .o_mosi     (w_mosi),
    .o_sclkTick (w_sclkTick)
  );

  spi_slave s1 (
    .clk        (clk),
    .rst        (rst),
    .i_sclk     (w_sclk),
    .i_sclkTick (w_sclkTick),
    .i_cs       (w_cs),
    .i_mosi     (w_mosi),
    .o_dout     (dout),
    .o_done     (done)
  );

endmodule

// File: tb/tb_spi_loopback_top.sv
// Bench for the SPI loopback: stimulus pushes expected words into a queue,
// a monitor pops and compares them whenever done pulses.
interface spi_if;
  import spi_pkg::*;
  logic              clk;
  logic              rst;
  logic              newd;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              done;
  logic              sclk;
endinterface

module tb_spi_loopback_top;
  import spi_pkg::*;

  spi_if bus ();

  int                passCount = 0;
  int                checkCount = 0;
  int                doneCount = 0;
  logic              prevDone = 1'b0;
  logic [DATA_W-1:0] expQ[$];
  logic [DATA_W-1:0] expWord;

  spi_loopback_top dut (
    .clk  (bus.clk),
    .rst  (bus.rst),
    .newd (bus.newd),
    .din  (bus.din),
    .dout (bus.dout),
    .done (bus.done)
  );

  assign bus.sclk = dut.m1.sclk;

  // Free-running system clock.
  initial bus.clk = 1'b0;
  always #5 bus.clk = ~bus.clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic [DATA_W-1:0] word, input bit expectIt);
    @(negedge bus.clk);
    bus.din  = word;
    bus.newd = 1'b1;
    if (expectIt) expQ.push_back(word);
    @(negedge bus.clk);
    bus.newd = 1'b0;
  endtask

  task automatic waitDone(input int target, input int budget);
    int n = 0;
    while (doneCount < target && n < budget) begin
      @(negedge bus.clk);
      n++;
    end
    checkOutput("doneSeen", 32'(doneCount >= target), 32'd1);
  endtask

  task automatic waitCs(input logic level, input int budget, output int n);
    n = 0;
    while (dut.m1.o_cs !== level && n < budget) begin
      @(negedge bus.clk);
      n++;
    end
    checkOutput("csLevel", 32'(dut.m1.o_cs), 32'(level));
  endtask

  // Monitor: every done pulse must match the oldest queued word and last one cycle.
  always @(negedge bus.clk) begin
    if (prevDone) checkOutput("donePulseWidth", 32'(bus.done), 32'd0);
    if (bus.done === 1'b1) begin
      checkOutput("doneExpected", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        expWord = expQ.pop_front();
        checkOutput("dout", 32'(bus.dout), 32'(expWord));
      end
      doneCount++;
    end
    prevDone = bus.done;
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Directed stimulus sequence.
  initial begin
    logic [DATA_W-1:0] burst[5];
    logic [DATA_W-1:0] word;
    logic              prevSclk;
    int                n;
    int                bitIdx;
    int                target;

    burst = '{12'h3A7, 12'hC18, 12'h5F0, 12'h00F, 12'h9E6};

    bus.rst  = 1'b1;
    bus.newd = 1'b0;
    bus.din  = '0;
    repeat (5) @(negedge bus.clk);
    checkOutput("resetDout", 32'(bus.dout), 32'd0);
    checkOutput("resetDone", 32'(bus.done), 32'd0);
    checkOutput("resetCs", 32'(dut.m1.o_cs), 32'd1);
    checkOutput("resetMosi", 32'(dut.m1.o_mosi), 32'd0);
    checkOutput("resetSclk", 32'(bus.sclk), 32'd0);
    bus.rst = 1'b0;
    n = 0;
    while (bus.sclk !== 1'b1 && n < 5 * CLK_DIV) begin
      @(negedge bus.clk);
      n++;
    end
    checkOutput("sclkFirstRise", 32'(n), 32'(CLK_DIV));

    // A5C: capture the mosi bit at each sclk fall and time the done pulse.
    applyStimulus(12'hA5C, 1'b1);
    waitCs(1'b0, 4 * CLK_DIV, n);
    prevSclk = bus.sclk;
    bitIdx   = 0;
    word     = '0;
    n        = 0;
    while (bus.done !== 1'b1 && n < 400) begin
      @(negedge bus.clk);
      n++;
      if (prevSclk && !bus.sclk && bitIdx < DATA_W) begin
        word[bitIdx] = dut.m1.o_mosi;
        bitIdx++;
      end
      prevSclk = bus.sclk;
    end
    checkOutput("mosiSequence", 32'(word), 32'h0A5C);
    checkOutput("mosiBitCount", 32'(bitIdx), 32'(DATA_W));
    checkOutput("doneLatency", 32'(n), 32'(2 * DATA_W * CLK_DIV - CLK_DIV));
    waitCs(1'b1, 3 * CLK_DIV, n);
    checkOutput("csRiseDelay", 32'(n), 32'(CLK_DIV));
    checkOutput("mosiIdle", 32'(dut.m1.o_mosi), 32'd0);

    // All-zeros and all-ones words.
    target = doneCount + 1;
    applyStimulus(12'h000, 1'b1);
    waitDone(target, 600);
    repeat (CLK_DIV + 2) @(negedge bus.clk);
    target = doneCount + 1;
    applyStimulus(12'hFFF, 1'b1);
    waitDone(target, 600);
    repeat (CLK_DIV + 2) @(negedge bus.clk);

    // Back-to-back burst, each request issued once the previous frame closed.
    for (int i = 0; i < 5; i++) begin
      target = doneCount + 1;
      applyStimulus(burst[i], 1'b1);
      waitDone(target, 600);
      repeat (CLK_DIV + 2) @(negedge bus.clk);
    end

    // A request during SEND must be dropped.
    target = doneCount + 1;
    applyStimulus(12'h123, 1'b1);
    waitCs(1'b0, 4 * CLK_DIV, n);
    repeat (50) @(negedge bus.clk);
    applyStimulus(12'h456, 1'b0);
    waitDone(target, 600);
    repeat (600) @(negedge bus.clk);
    checkOutput("noSecondDone", 32'(doneCount), 32'(target));
    checkOutput("doutHold", 32'(bus.dout), 32'h0123);

    // Reset after five bits of 3C3, then a clean 081 frame.
    target = doneCount;
    applyStimulus(12'h3C3, 1'b0);
    waitCs(1'b0, 4 * CLK_DIV, n);
    repeat (10 * CLK_DIV - 5) @(negedge bus.clk);
    bus.rst = 1'b1;
    repeat (3) @(negedge bus.clk);
    checkOutput("abortDout", 32'(bus.dout), 32'd0);
    checkOutput("abortCs", 32'(dut.m1.o_cs), 32'd1);
    checkOutput("abortMosi", 32'(dut.m1.o_mosi), 32'd0);
    checkOutput("abortSclk", 32'(bus.sclk), 32'd0);
    bus.rst = 1'b0;
    checkOutput("noDoneInAbort", 32'(doneCount), 32'(target));
    target = doneCount + 1;
    applyStimulus(12'h081, 1'b1);
    waitDone(target, 600);
    repeat (CLK_DIV + 2) @(negedge bus.clk);

    checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
